// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data bus arbiter slice.
//   DATA_W      : data path width
//   size_e      : RV32I load/store size encodings taken from funct3[1:0]
//   req_id_e    : requester identifiers used for ownership and round-robin
package data_bus_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DMA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/bus_store_align.sv
// Combinational byte-lane generator for one bus access.
//   funct3     : RV32I size encoding (bit 2, the unsigned-load flag, has no lane effect)
//   addr_lo    : byte offset within the word
//   wdata      : store data, valid in the low bits
//   we         : 1 = store, 0 = load
//   be         : byte enables (all lanes for loads)
//   wdata_rep  : store data replicated across lanes
//   misaligned : access straddles its natural boundary or uses a reserved size
module bus_store_align
  import data_bus_arbiter_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic              misaligned
);

  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  always_comb begin
    be         = '0;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (size_e'(funct3[1:0]))
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_H: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      SIZE_W: begin
        be         = '1;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        be         = '0;
        misaligned = 1'b1;
      end
    endcase
    // Loads always fetch the whole word; lane selection happens downstream.
    if (!we) be = '1;
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
//   clk_in, reset          : clock and synchronous active-low reset
//   core_* / dma_*         : request, write flag, byte address, store data, funct3
//   core_gnt / dma_gnt     : request accepted this cycle (combinational)
//   core_rvalid/dma_rvalid : one-cycle response pulse, one cycle after the grant
//   rsp_rdata, rsp_err     : response word (0 for stores/errors) and misaligned flag
//   mem_*                  : RAM port; mem_rdata returns one cycle after mem_en
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_funct3,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic [2:0]        dma_funct3,
  output logic              core_gnt,
  output logic              dma_gnt,
  output logic              core_rvalid,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [29:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic    pending, pending_nxt;
  req_id_e owner, owner_nxt;
  logic    pending_is_write, pending_is_write_nxt;
  logic    pending_err, pending_err_nxt;
  req_id_e last_grant, last_grant_nxt;

  req_id_e           win;
  logic              any_gnt;
  logic              rsp_valid;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_funct3;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic              al_mis;

  // Winner's payload feeds a single aligner instance.
  always_comb begin
    sel_we     = core_we;
    sel_addr   = core_addr;
    sel_wdata  = core_wdata;
    sel_funct3 = core_funct3;
    if (win == REQ_DMA) begin
      sel_we     = dma_we;
      sel_addr   = dma_addr;
      sel_wdata  = dma_wdata;
      sel_funct3 = dma_funct3;
    end
  end

  bus_store_align u_align (
    .funct3     (sel_funct3),
    .addr_lo    (sel_addr[1:0]),
    .wdata      (sel_wdata),
    .we         (sel_we),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .misaligned (al_mis)
  );

  // State register
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      pending          <= 1'b0;
      owner            <= REQ_CORE;
      pending_is_write <= 1'b0;
      pending_err      <= 1'b0;
      last_grant       <= REQ_DMA;
    end else begin
      pending          <= pending_nxt;
      owner            <= owner_nxt;
      pending_is_write <= pending_is_write_nxt;
      pending_err      <= pending_err_nxt;
      last_grant       <= last_grant_nxt;
    end
  end

  // Next state: a grant always launches a response for the following cycle,
  // independent of whether the previous response is being delivered now.
  always_comb begin
    pending_nxt          = any_gnt;
    owner_nxt            = owner;
    pending_is_write_nxt = pending_is_write;
    pending_err_nxt      = pending_err;
    last_grant_nxt       = last_grant;
    if (any_gnt) begin
      owner_nxt            = win;
      pending_is_write_nxt = sel_we;
      pending_err_nxt      = al_mis;
      last_grant_nxt       = win;
    end
  end

  // Outputs: arbitration, RAM port and response
  always_comb begin
    win       = REQ_CORE;
    any_gnt   = 1'b0;
    core_gnt  = 1'b0;
    dma_gnt   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (core_req && dma_req)
        win = (last_grant == REQ_DMA) ? REQ_CORE : REQ_DMA;
      else if (dma_req)
        win = REQ_DMA;
      any_gnt  = core_req | dma_req;
      core_gnt = any_gnt && (win == REQ_CORE);
      dma_gnt  = any_gnt && (win == REQ_DMA);
      if (any_gnt) begin
        mem_en    = ~al_mis;
        mem_we    = sel_we & ~al_mis;
        mem_be    = al_be;
        mem_addr  = sel_addr[31:2];
        mem_wdata = al_wdata;
      end
    end

    // Gating with reset discards a response that was in flight at reset entry.
    rsp_valid   = pending & reset;
    core_rvalid = rsp_valid && (owner == REQ_CORE);
    dma_rvalid  = rsp_valid && (owner == REQ_DMA);
    rsp_err     = rsp_valid & pending_err;
    rsp_rdata   = (rsp_valid && !pending_is_write && !pending_err) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        core_req, core_we, dma_req, dma_we;
  logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
  logic [2:0]  core_funct3, dma_funct3;
  logic        core_gnt, dma_gnt, core_rvalid, dma_rvalid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  data_bus_arbiter dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_funct3 (core_funct3),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_funct3  (dma_funct3),
    .core_gnt    (core_gnt),
    .dma_gnt     (dma_gnt),
    .core_rvalid (core_rvalid),
    .dma_rvalid  (dma_rvalid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Read-only RAM: word n holds 0xA000_0000 + n.
  always @(posedge clk_in)
    if (mem_en && !mem_we) mem_rdata <= 32'hA000_0000 | {2'b00, mem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_funct3 = 3'b010;
    dma_req  = 0; dma_we  = 0; dma_addr  = '0; dma_wdata  = '0; dma_funct3  = 3'b010;
  endtask

  task automatic drive_core(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f3);
    core_req = 1; core_we = we; core_addr = a; core_wdata = d; core_funct3 = f3;
  endtask

  task automatic drive_dma(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3);
    dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d; dma_funct3 = f3;
  endtask

  task automatic next_cycle;
    @(posedge clk_in); #1;
  endtask

  initial begin
    idle();
    reset = 0;
    // Reset with a pending core store request: everything held at zero.
    drive_core(1, 32'h8, 32'hDEADBEEF, 3'b010);
    @(negedge clk_in);
    chk("rst_core_gnt", core_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rvalid", {core_rvalid, dma_rvalid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    next_cycle();
    next_cycle();
    reset = 1;

    // Core SW 0x8
    @(negedge clk_in);
    chk("sw_core_gnt", core_gnt, 1);
    chk("sw_dma_gnt", dma_gnt, 0);
    chk("sw_en", mem_en, 1);
    chk("sw_we", mem_we, 1);
    chk("sw_addr", mem_addr, 30'h2);
    chk("sw_be", mem_be, 4'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_no_early_rvalid", core_rvalid, 0);
    next_cycle(); idle();
    @(negedge clk_in);
    chk("sw_rvalid", core_rvalid, 1);
    chk("sw_dma_rvalid", dma_rvalid, 0);
    chk("sw_err", rsp_err, 0);
    chk("sw_rdata", rsp_rdata, 0);
    chk("sw_idle_gnt", core_gnt, 0);
    next_cycle();
    @(negedge clk_in);
    chk("sw_rvalid_once", core_rvalid, 0);

    // Core SB 0x13
    drive_core(1, 32'h13, 32'h000000A5, 3'b000);
    @(negedge clk_in);
    chk("sb_gnt", core_gnt, 1);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_addr", mem_addr, 30'h4);
    next_cycle(); idle();
    @(negedge clk_in);
    chk("sb_rvalid", core_rvalid, 1);

    // Core SH 0x16 (upper half lanes)
    next_cycle();
    drive_core(1, 32'h16, 32'h1234BEEF, 3'b001);
    @(negedge clk_in);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("sh_addr", mem_addr, 30'h5);
    next_cycle(); idle();

    // Core SH 0x15: misaligned, granted but RAM untouched
    drive_core(1, 32'h15, 32'h0000BEEF, 3'b001);
    @(negedge clk_in);
    chk("shmis_gnt", core_gnt, 1);
    chk("shmis_en", mem_en, 0);
    chk("shmis_we", mem_we, 0);
    next_cycle(); idle();
    @(negedge clk_in);
    chk("shmis_rvalid", core_rvalid, 1);
    chk("shmis_err", rsp_err, 1);
    chk("shmis_rdata", rsp_rdata, 0);

    // Contention after reset: core, dma, core, dma
    next_cycle();
    reset = 0;
    next_cycle();
    reset = 1;
    drive_core(0, 32'h0, 32'h0, 3'b010);
    drive_dma(0, 32'h4, 32'h0, 3'b010);
    @(negedge clk_in);
    chk("rr1_gnt", {core_gnt, dma_gnt}, 2'b10);
    chk("rr1_addr", mem_addr, 30'h0);
    chk("rr1_rvalid", {core_rvalid, dma_rvalid}, 2'b00);
    next_cycle();
    @(negedge clk_in);
    chk("rr2_gnt", {core_gnt, dma_gnt}, 2'b01);
    chk("rr2_addr", mem_addr, 30'h1);
    chk("rr2_rvalid", {core_rvalid, dma_rvalid}, 2'b10);
    chk("rr2_rdata", rsp_rdata, 32'hA0000000);
    next_cycle();
    @(negedge clk_in);
    chk("rr3_gnt", {core_gnt, dma_gnt}, 2'b10);
    chk("rr3_rvalid", {core_rvalid, dma_rvalid}, 2'b01);
    chk("rr3_rdata", rsp_rdata, 32'hA0000001);
    next_cycle();
    @(negedge clk_in);
    chk("rr4_gnt", {core_gnt, dma_gnt}, 2'b01);
    chk("rr4_rvalid", {core_rvalid, dma_rvalid}, 2'b10);
    chk("rr4_rdata", rsp_rdata, 32'hA0000000);
    next_cycle(); idle();
    @(negedge clk_in);
    chk("rr5_gnt", {core_gnt, dma_gnt}, 2'b00);
    chk("rr5_rvalid", {core_rvalid, dma_rvalid}, 2'b01);
    chk("rr5_rdata", rsp_rdata, 32'hA0000001);
    next_cycle();

    // DMA LW 0x6: misaligned word
    drive_dma(0, 32'h6, 32'h0, 3'b010);
    @(negedge clk_in);
    chk("lwmis_gnt", {core_gnt, dma_gnt}, 2'b01);
    chk("lwmis_en", mem_en, 0);
    next_cycle(); idle();
    @(negedge clk_in);
    chk("lwmis_rvalid", {core_rvalid, dma_rvalid}, 2'b01);
    chk("lwmis_err", rsp_err, 1);
    chk("lwmis_rdata", rsp_rdata, 0);
    next_cycle();

    // DMA access with reserved size 11 at an aligned address
    drive_dma(0, 32'h0, 32'h0, 3'b011);
    @(negedge clk_in);
    chk("sz11_en", mem_en, 0);
    next_cycle(); idle();
    @(negedge clk_in);
    chk("sz11_err", rsp_err, 1);
    next_cycle();

    // Core LH 0x2 then LW 0x4 back-to-back
    drive_core(0, 32'h2, 32'h0, 3'b001);
    @(negedge clk_in);
    chk("b2b1_gnt", core_gnt, 1);
    chk("b2b1_be", mem_be, 4'hF);
    chk("b2b1_we", mem_we, 0);
    chk("b2b1_addr", mem_addr, 30'h0);
    next_cycle();
    drive_core(0, 32'h4, 32'h0, 3'b010);
    @(negedge clk_in);
    chk("b2b2_gnt", core_gnt, 1);
    chk("b2b2_addr", mem_addr, 30'h1);
    chk("b2b2_rvalid", core_rvalid, 1);
    chk("b2b2_rdata", rsp_rdata, 32'hA0000000);
    next_cycle(); idle();
    @(negedge clk_in);
    chk("b2b3_rvalid", core_rvalid, 1);
    chk("b2b3_rdata", rsp_rdata, 32'hA0000001);
    chk("b2b3_gnt", core_gnt, 0);
    next_cycle();

    // Core read granted, then reset on the following edge
    drive_core(0, 32'h0, 32'h0, 3'b010);
    @(negedge clk_in);
    chk("rstmid_gnt", core_gnt, 1);
    next_cycle();
    reset = 0;
    @(negedge clk_in);
    chk("rstmid_rvalid", {core_rvalid, dma_rvalid}, 2'b00);
    chk("rstmid_gnt2", {core_gnt, dma_gnt}, 2'b00);
    chk("rstmid_rdata", rsp_rdata, 0);
    chk("rstmid_mem", {mem_en, mem_we, mem_be}, 0);
    next_cycle(); idle();
    reset = 1;
    @(negedge clk_in);
    chk("rstmid_after", {core_rvalid, dma_rvalid, rsp_err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_in input 1 rising-edge clock; reset input 1 synchronous active-low reset (0 = reset).
REQ-002 core_req input 1 core access request; core_we input 1 write=1/read=0; core_addr input 32 byte address; core_wdata input 32 store data (low bits valid); core_funct3 input 3 access size (RV32I load/store encoding).
REQ-003 dma_req, dma_we, dma_addr, dma_wdata, dma_funct3 SHALL be inputs with the same widths and meanings as the core_* inputs, for the DMA/loader requester.
REQ-004 core_gnt output 1 and dma_gnt output 1: request accepted this cycle.
REQ-005 core_rvalid output 1 and dma_rvalid output 1: response for that requester this cycle.
REQ-006 rsp_rdata output 32: raw RAM word; rsp_err output 1: misaligned access.
REQ-007 mem_en output 1, mem_we output 1, mem_be output 4, mem_addr output 30 (word address = addr[31:2]), mem_wdata output 32, mem_rdata input 32: single-port synchronous RAM, 1-cycle read latency.

Function
REQ-008 Arbitration SHALL be two-way round-robin: with both requests asserted, the requester not granted most recently wins; a single request always wins.
REQ-009 Grant SHALL be combinational in the request cycle, and at most one gnt SHALL be high per cycle.
REQ-010 A requester SHALL hold req and all payload stable until its gnt is high; the request is consumed on that edge.
REQ-011 In the grant cycle, mem_en, mem_we, mem_be, mem_addr and mem_wdata SHALL carry the winner's access.
REQ-012 Exactly one cycle after any grant, the winner's rvalid SHALL pulse high for one cycle, for both reads and writes.
REQ-013 During rvalid for a read, rsp_data SHALL equal mem_rdata; during rvalid for a write, rsp_rdata SHALL be 0.
REQ-014 A new grant MAY issue in the same cycle as a previous rvalid, giving back-to-back throughput of one access per cycle.
REQ-015 Byte enables SHALL be generated from funct3[1:0] and addr[1:0] as follows: byte 00 -> 4'b0001 << addr[1:0]; half 01 -> 4'b0011 << {addr[1],1'b0}; word 10 -> 4'b1111.
REQ-016 Store data SHALL be replicated across lanes: byte x4 lanes, half x2 lanes, word as-is.
REQ-017 For reads, mem_we SHALL be 0 and mem_be SHALL be 4'b1111.
REQ-018 An access SHALL be misaligned when it is half with addr[0]=1, word with addr[1:0]!=0, or funct3[1:0]=11.
REQ-019 A misaligned access SHALL still be granted, with mem_en=0, and its rvalid SHALL carry rsp_err=1 and rsp_rdata=0.
REQ-020 Internal state SHALL consist of: pending (1b), owner (1b), pending_is_write (1b), pending_err (1b), last_grant (1b).
REQ-021 If a requester drops req without a grant, no state SHALL change.

Reset
REQ-022 While reset=0, all gnt, rvalid, mem_en, mem_we and rsp_err outputs SHALL be 0; mem_be, mem_addr, mem_wdata and rsp_rdata SHALL be 0; pending SHALL be 0.
REQ-023 last_grant SHALL reset to DMA, so that the core wins the first contention.
REQ-024 A pending response at reset assertion SHALL be discarded, and no rvalid SHALL appear after reset release.

Structure
REQ-025 A shared package SHALL hold the funct3 size encodings (SIZE_B=2'b00, SIZE_H=2'b01, SIZE_W=2'b10), the requester IDs (REQ_CORE=0, REQ_DMA=1) and the data width 32.
REQ-026 One combinational sub-module, bus_store_align, SHALL produce mem_be, replicated mem_wdata and the misaligned flag from funct3, addr[1:0], wdata and we.

Verification
REQ-027 Core SW, addr 0x0000_0008, data 0xDEADBEEF, no DMA -> core_gnt same cycle, mem_addr=0x2, mem_be=1111; core_rvalid next cycle, rsp_err=0.
REQ-028 Core SB, addr 0x13, data 0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-029 Both req high for 4 cycles after reset -> grants alternate core, dma, core, dma; each rvalid arrives one cycle after its grant.
REQ-030 DMA LW at 0x6 -> dma_gnt=1, mem_en=0; next cycle dma_rvalid=1, rsp_err=1, rsp_rdata=0.
REQ-031 Core read granted, reset=0 on the following edge -> no core_rvalid; all outputs 0 while reset=0.
REQ-032 Core LH at 0x2 followed back-to-back by core LW at 0x4 -> two consecutive grants; rvalid on cycles 2 and 3 with rsp_rdata = RAM words 0 and 1.
